// File: rtl/ula_pkg.sv
// Shared definitions for the 8-bit accumulator ALU: command codes,
// handshake FSM states and flag bit positions inside the flag register.
package ula_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000,
    CMD_AND  = 3'b001,
    CMD_OR   = 3'b010,
    CMD_NOT  = 3'b011,
    CMD_LOAD = 3'b100,
    CMD_CLR  = 3'b101,
    CMD_NOP0 = 3'b110,
    CMD_NOP1 = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Positions inside the 4-bit flag register.
  localparam int FLAG_C  = 0;
  localparam int FLAG_OV = 1;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_N  = 3;
  localparam int FLAG_W  = 4;

endpackage

// File: rtl/ula_acc_core.sv
// Combinational result and flag computation for one accumulator command.
// The accumulator register itself lives in the parent.
module ula_acc_core
  import ula_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] operand,
  input  logic [2:0] cmd,
  output logic [7:0] r,
  output logic       c,
  output logic       ov,
  output logic       z,
  output logic       n
);

  logic [8:0] sum_s;

  // Select the result by command; carry/overflow are only meaningful for ADD.
  always_comb begin
    sum_s = {1'b0, acc} + {1'b0, operand};
    r     = acc;
    c     = 1'b0;
    ov    = 1'b0;
    case (cmd)
      CMD_ADD: begin
        r  = sum_s[7:0];
        c  = sum_s[8];
        ov = (acc[7] == operand[7]) && (sum_s[7] != acc[7]);
      end
      CMD_AND:  r = acc & operand;
      CMD_OR:   r = acc | operand;
      CMD_NOT:  r = ~acc;
      CMD_LOAD: r = operand;
      CMD_CLR:  r = 8'h00;
      default:  r = acc;
    endcase
    z = (r == 8'h00);
    n = r[7];
  end

endmodule

// File: rtl/ula_acc_8b.sv
// 8-bit accumulator ALU with a valid/ready command port and a held result.
// FSM: IDLE accepts a command, EXEC updates acc/flags, RESP holds them
// until the consumer takes the result.
// Optional feature: define ULA_ACC_STICKY_OV_EN to build the sticky
// overflow register; otherwise ov_sticky is a constant 0.
module ula_acc_8b
  import ula_pkg::*;
#(
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] operand,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] acc,
  output logic       c,
  output logic       ov,
  output logic       z,
  output logic       n,
  output logic       ov_sticky
);

  state_e              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [7:0]          opnd_q, opnd_d;
  logic [7:0]          acc_q, acc_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [7:0]          core_r;
  logic                core_c, core_ov, core_z, core_n;

  ula_acc_core u_core (
    .acc     (acc_q),
    .operand (opnd_q),
    .cmd     (cmd_q),
    .r       (core_r),
    .c       (core_c),
    .ov      (core_ov),
    .z       (core_z),
    .n       (core_n)
  );

  // Next state, command capture and the EXEC-cycle register update.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cmd_d   = cmd;
          opnd_d  = operand;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        acc_d            = core_r;
        flags_d[FLAG_C]  = core_c;
        flags_d[FLAG_OV] = core_ov;
        flags_d[FLAG_Z]  = core_z;
        flags_d[FLAG_N]  = core_n;
        state_d          = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered from the next state so they are glitch-free.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_RESP);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cmd_q            <= CMD_NOP0;
      opnd_q           <= 8'h00;
      acc_q            <= ACC_INIT;
      flags_q          <= '0;
      flags_q[FLAG_Z]  <= (ACC_INIT == 8'h00);
      in_ready_q       <= 1'b1;
      out_valid_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ULA_ACC_STICKY_OV_EN
  logic ov_sticky_q, ov_sticky_d;

  // Sticky overflow: set by an overflowing ADD, cleared only by CLR or reset.
  always_comb begin
    ov_sticky_d = ov_sticky_q;
    if (state_q == ST_EXEC) begin
      if (cmd_q == CMD_CLR) begin
        ov_sticky_d = 1'b0;
      end else if ((cmd_q == CMD_ADD) && core_ov) begin
        ov_sticky_d = 1'b1;
      end else begin
        ov_sticky_d = ov_sticky_q;
      end
    end else begin
      ov_sticky_d = ov_sticky_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_sticky_q <= 1'b0;
    end else begin
      ov_sticky_q <= ov_sticky_d;
    end
  end

  assign ov_sticky = ov_sticky_q;
`else
  assign ov_sticky = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign c         = flags_q[FLAG_C];
  assign ov        = flags_q[FLAG_OV];
  assign z         = flags_q[FLAG_Z];
  assign n         = flags_q[FLAG_N];

endmodule

// File: tb/tb_ula_acc_8b.sv
// Directed self-checking bench for ula_acc_8b (ACC_INIT = 8'h00).
// Outputs are sampled 1 time unit after each rising edge.
module tb_ula_acc_8b;

`ifdef ULA_ACC_STICKY_OV_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] cmd = 3'b110;
  logic [7:0] operand = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] acc;
  logic       c, ov, z, n, ov_sticky;

  int errors = 0;
  int checks = 0;

  ula_acc_8b #(.ACC_INIT(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd       (cmd),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .c         (c),
    .ov        (ov),
    .z         (z),
    .n         (n),
    .ov_sticky (ov_sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare acc and all flags against hand-computed values.
  task automatic chk_res(input string tag, input logic [7:0] e_acc,
                         input logic e_c, input logic e_ov, input logic e_z, input logic e_n);
    chk({tag, ".acc"}, acc, e_acc);
    chk({tag, ".cnzv"}, {4'h0, c, n, z, ov}, {4'h0, e_c, e_n, e_z, e_ov});
  endtask

  // Offer a command, wait (bounded) for acceptance, then scramble the inputs.
  task automatic accept(input logic [2:0] k, input logic [7:0] op);
    int w;
    in_valid = 1'b1;
    cmd      = k;
    operand  = op;
    w = 0;
    while (!in_ready && w < 10) begin
      step();
      w++;
    end
    chk("accept_ready", {7'h0, in_ready}, 8'h01);
    step();
    in_valid = 1'b0;
    cmd      = ~k;
    operand  = ~op;
    chk("exec_out_valid", {7'h0, out_valid}, 8'h00);
    chk("exec_in_ready", {7'h0, in_ready}, 8'h00);
  endtask

  // Full command up to RESP: out_valid must be high two cycles after offering.
  task automatic run(input logic [2:0] k, input logic [7:0] op);
    accept(k, op);
    step();
    chk("resp_out_valid", {7'h0, out_valid}, 8'h01);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_out_valid", {7'h0, out_valid}, 8'h00);
    chk("idle_in_ready", {7'h0, in_ready}, 8'h01);
  endtask

  initial begin
    // Reset and the first cycle after release.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk_res("reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset_in_ready", {7'h0, in_ready}, 8'h01);
    chk("reset_out_valid", {7'h0, out_valid}, 8'h00);
    chk("reset_sticky", {7'h0, ov_sticky}, 8'h00);
    step();
    chk_res("idle_hold", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Signed overflow: 0x7F + 0x01.
    run(3'b100, 8'h7F); chk_res("load7f", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0); handshake();
    run(3'b000, 8'h01); chk_res("add_ov", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("add_ov_sticky", {7'h0, ov_sticky}, {7'h0, STICKY});
    handshake();

    // Unsigned carry: 0xFF + 0x01.
    run(3'b100, 8'hFF); chk_res("loadff", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1); handshake();
    run(3'b000, 8'h01); chk_res("add_carry", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0); handshake();

    // Logic chain.
    run(3'b100, 8'h0F); chk_res("load0f", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0); handshake();
    run(3'b011, 8'hAA); chk_res("not", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1); handshake();
    run(3'b001, 8'h3C); chk_res("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0); handshake();
    run(3'b010, 8'h01); chk_res("or", 8'h31, 1'b0, 1'b0, 1'b0, 1'b0); handshake();

    // 0x31 + 0xFF = 0x130: carry, no signed overflow; then NOP clears carry.
    run(3'b000, 8'hFF); chk_res("add_c2", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0); handshake();
    run(3'b110, 8'h55); chk_res("nop", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0); handshake();
    run(3'b101, 8'h55); chk_res("clr", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); handshake();

    // Back-pressure: hold RESP for 3 cycles while a new command is offered.
    run(3'b100, 8'hA5);
    in_valid = 1'b1;
    cmd      = 3'b101;
    operand  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_res("hold", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("hold_out_valid", {7'h0, out_valid}, 8'h01);
      chk("hold_in_ready", {7'h0, in_ready}, 8'h00);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("after_hs_in_ready", {7'h0, in_ready}, 8'h01);
    chk_res("after_hs_not_taken", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    accept(3'b101, 8'h00);
    step();
    chk("clr2_out_valid", {7'h0, out_valid}, 8'h01);
    chk_res("clr2", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    handshake();

    // Reset during EXEC discards the command.
    run(3'b100, 8'h10); chk_res("load10", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0); handshake();
    accept(3'b000, 8'h05);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_res("rst_exec", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_exec_in_ready", {7'h0, in_ready}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      chk("rst_exec_no_valid", {7'h0, out_valid}, 8'h00);
      chk("rst_exec_acc", acc, 8'h00);
      step();
    end

    // Sticky overflow survives LOAD, cleared by CLR.
    run(3'b100, 8'h7F); handshake();
    run(3'b000, 8'h01); chk_res("st_add", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1); handshake();
    run(3'b100, 8'h00); chk_res("st_load", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("st_load_sticky", {7'h0, ov_sticky}, {7'h0, STICKY});
    handshake();
    run(3'b101, 8'h00);
    chk("st_clr_sticky", {7'h0, ov_sticky}, 8'h00);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
